// File: rtl/block_map_pkg.sv
// Shared definitions for the brick map: geometry defaults, block codes,
// hit result encodings, controller states and the hit update rule.
package block_map_pkg;

    localparam int unsigned MAP_COLS  = 10;
    localparam int unsigned MAP_ROWS  = 30;
    localparam int unsigned MAP_CNT_W = 9;
    localparam int unsigned CODE_W    = 3;
    localparam int unsigned RES_W     = 2;

    localparam logic [CODE_W-1:0] BLK_NONE   = 3'b000;
    localparam logic [CODE_W-1:0] BLK_RED    = 3'b001;
    localparam logic [CODE_W-1:0] BLK_ORANGE = 3'b010;
    localparam logic [CODE_W-1:0] BLK_HARD   = 3'b011;
    localparam logic [CODE_W-1:0] BLK_BLUE   = 3'b100;
    localparam logic [CODE_W-1:0] BLK_CYAN   = 3'b101;
    localparam logic [CODE_W-1:0] BLK_PINK   = 3'b110;
    localparam logic [CODE_W-1:0] BLK_WHITE  = 3'b111;

    localparam logic [RES_W-1:0] HIT_MISS      = 2'b00;
    localparam logic [RES_W-1:0] HIT_DAMAGED   = 2'b01;
    localparam logic [RES_W-1:0] HIT_DESTROYED = 2'b10;
    localparam logic [RES_W-1:0] HIT_INDESTR   = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_HIT_RD,
        ST_HIT_WR
    } state_t;

    typedef struct packed {
        logic [CODE_W-1:0] code;
        logic [RES_W-1:0]  result;
    } hit_outcome_t;

    // A brick counts toward the remaining total unless empty or white
    function automatic logic is_destructible(input logic [CODE_W-1:0] c);
        return (c != BLK_NONE) && (c != BLK_WHITE);
    endfunction

    // Replacement code and result for one hit on a cell holding 'old'
    function automatic hit_outcome_t hit_update(input logic [CODE_W-1:0] old);
        hit_outcome_t o;
        o.code   = BLK_NONE;
        o.result = HIT_DESTROYED;
        case (old)
            BLK_NONE: o.result = HIT_MISS;
            BLK_HARD: begin
                o.code   = BLK_RED;
                o.result = HIT_DAMAGED;
            end
            BLK_WHITE: begin
                o.code   = BLK_WHITE;
                o.result = HIT_INDESTR;
            end
            default: ;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/level_rom.sv
// Level pattern ROM: combinational (level,row,col) -> block code.
module level_rom
    import block_map_pkg::*;
(
    input  logic [1:0]        level,
    input  logic [4:0]        row,
    input  logic [4:0]        col,
    output logic [CODE_W-1:0] code
);

    // Pattern decode; cells outside a level's band are empty
    always_comb begin
        code = BLK_NONE;
        case (level)
            2'd0: begin
                if (row >= 5'd2 && row <= 5'd7) begin
                    case (2'(row - 5'd2))
                        2'd0:    code = BLK_BLUE;
                        2'd1:    code = BLK_CYAN;
                        2'd2:    code = BLK_PINK;
                        default: code = BLK_WHITE;
                    endcase
                end
            end
            2'd1: begin
                if (row >= 5'd1 && row <= 5'd8)
                    code = (row[0] ^ col[0]) ? BLK_RED : BLK_ORANGE;
            end
            2'd2: begin
                if (row >= 5'd3 && row <= 5'd10)
                    code = (col == 5'd0 || col == 5'(MAP_COLS - 1)) ? BLK_WHITE : BLK_HARD;
            end
            default: begin
                if (row <= 5'd11)
                    code = {1'b1, col[1:0]};
            end
        endcase
    end

endmodule

// File: rtl/block_map_ctrl.sv
// Brick map controller: owns the map, loads level patterns, serialises hit
// read-modify-writes and tracks remaining destructible bricks.
// Optional feature macro: BLOCK_MAP_SCORE_EN adds the score port and logic.
module block_map_ctrl
    import block_map_pkg::*;
#(
    parameter int unsigned COLS  = MAP_COLS,
    parameter int unsigned ROWS  = MAP_ROWS,
    parameter int unsigned CNT_W = MAP_CNT_W
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [4:0]         sel_row,
    input  logic [4:0]         sel_col,
    output logic [CODE_W-1:0]  block,
    input  logic               load_start,
    input  logic [1:0]         level,
    output logic               load_busy,
    output logic               load_done,
    input  logic               hit_req,
    input  logic [4:0]         hit_row,
    input  logic [4:0]         hit_col,
    output logic               hit_ack,
    output logic [RES_W-1:0]   hit_result,
    output logic [CNT_W-1:0]   remaining,
    output logic               level_clear
`ifdef BLOCK_MAP_SCORE_EN
    ,
    output logic [15:0]        score
`endif
);

    localparam int unsigned ROW_AW = $clog2(ROWS);
    localparam int unsigned COL_AW = $clog2(COLS);

    state_t state, state_next;

    logic [CODE_W-1:0] map [ROWS][COLS];

    logic [ROW_AW-1:0] ld_row;
    logic [COL_AW-1:0] ld_col;
    logic [1:0]        ld_level;
    logic              loaded;
    logic              ld_last;

    logic [ROW_AW-1:0] hv_row;
    logic [COL_AW-1:0] hv_col;
    logic              hv_valid;
    logic [CODE_W-1:0] hv_code;

    logic [CODE_W-1:0] rom_code;
    hit_outcome_t      outcome;

    logic              map_we;
    logic [ROW_AW-1:0] wr_row;
    logic [COL_AW-1:0] wr_col;
    logic [CODE_W-1:0] wr_code;

    logic              load_go_c;
    logic              load_step_c;
    logic              load_last_c;
    logic              hit_cap_c;
    logic              hit_fire_c;
    logic              hit_ok;

    level_rom u_level_rom (
        .level (ld_level),
        .row   (5'(ld_row)),
        .col   (5'(ld_col)),
        .code  (rom_code)
    );

    assign ld_last = (ld_row == ROW_AW'(ROWS - 1)) && (ld_col == COL_AW'(COLS - 1));
    assign hit_ok  = (hit_row < 5'(ROWS)) && (hit_col < 5'(COLS));
    assign outcome = hit_update(hv_code);

    // Renderer read port; out-of-range selects read as empty
    always_comb begin
        block = BLK_NONE;
        if (sel_row < 5'(ROWS) && sel_col < 5'(COLS))
            block = map[ROW_AW'(sel_row)][COL_AW'(sel_col)];
    end

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_next;
    end

    // Next-state and control strobes; load wins over a pending hit
    always_comb begin
        state_next  = state;
        map_we      = 1'b0;
        wr_row      = ld_row;
        wr_col      = ld_col;
        wr_code     = rom_code;
        load_go_c   = 1'b0;
        load_step_c = 1'b0;
        load_last_c = 1'b0;
        hit_cap_c   = 1'b0;
        hit_fire_c  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (load_start) begin
                    load_go_c  = 1'b1;
                    state_next = ST_LOAD;
                end else if (hit_req) begin
                    state_next = ST_HIT_RD;
                end
            end
            ST_LOAD: begin
                map_we      = 1'b1;
                load_step_c = 1'b1;
                if (ld_last) begin
                    load_last_c = 1'b1;
                    state_next  = ST_IDLE;
                end
            end
            ST_HIT_RD: begin
                hit_cap_c  = 1'b1;
                state_next = ST_HIT_WR;
            end
            ST_HIT_WR: begin
                hit_fire_c = 1'b1;
                map_we     = hv_valid;
                wr_row     = hv_row;
                wr_col     = hv_col;
                wr_code    = outcome.code;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Map storage: single write port, cleared by reset
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int r = 0; r < ROWS; r++)
                for (int c = 0; c < COLS; c++)
                    map[r][c] <= BLK_NONE;
        end else if (map_we) begin
            map[wr_row][wr_col] <= wr_code;
        end
    end

    // Load cursor, hit capture, brick count and handshake outputs
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ld_row      <= '0;
            ld_col      <= '0;
            ld_level    <= '0;
            loaded      <= 1'b0;
            hv_row      <= '0;
            hv_col      <= '0;
            hv_valid    <= 1'b0;
            hv_code     <= BLK_NONE;
            load_busy   <= 1'b0;
            load_done   <= 1'b0;
            hit_ack     <= 1'b0;
            hit_result  <= HIT_MISS;
            remaining   <= '0;
            level_clear <= 1'b0;
        end else begin
            load_busy   <= (state_next == ST_LOAD);
            load_done   <= load_last_c;
            hit_ack     <= hit_fire_c;
            level_clear <= loaded && (remaining == '0) && !load_go_c;

            if (hit_fire_c)
                hit_result <= outcome.result;

            if (load_go_c) begin
                ld_row    <= '0;
                ld_col    <= '0;
                ld_level  <= level;
                loaded    <= 1'b0;
                remaining <= '0;
            end else if (load_step_c) begin
                if (ld_col == COL_AW'(COLS - 1)) begin
                    ld_col <= '0;
                    ld_row <= ld_row + ROW_AW'(1);
                end else begin
                    ld_col <= ld_col + COL_AW'(1);
                end
                if (is_destructible(rom_code))
                    remaining <= remaining + CNT_W'(1);
                if (load_last_c)
                    loaded <= 1'b1;
            end else if (hit_fire_c && outcome.result == HIT_DESTROYED && remaining != '0) begin
                remaining <= remaining - CNT_W'(1);
            end

            if (hit_cap_c) begin
                hv_valid <= hit_ok;
                hv_row   <= ROW_AW'(hit_row);
                hv_col   <= COL_AW'(hit_col);
                hv_code  <= hit_ok ? map[ROW_AW'(hit_row)][COL_AW'(hit_col)] : BLK_NONE;
            end
        end
    end

`ifdef BLOCK_MAP_SCORE_EN
    logic [16:0] score_sum;

    // Score increment for the completing hit
    always_comb begin
        score_sum = {1'b0, score};
        if (hit_fire_c) begin
            if (outcome.result == HIT_DAMAGED)
                score_sum = score_sum + 17'd10;
            else if (outcome.result == HIT_DESTROYED)
                score_sum = score_sum + 17'd50;
        end
    end

    // Score register, saturating; only reset clears it
    always_ff @(posedge clock or posedge reset) begin
        if (reset) score <= '0;
        else       score <= score_sum[16] ? 16'hFFFF : score_sum[15:0];
    end
`endif

endmodule

// File: tb/tb_block_map_ctrl.sv
// Self-checking bench for block_map_ctrl with a hit-result scoreboard.
// Score checks are compiled in when BLOCK_MAP_SCORE_EN is defined.
module tb_block_map_ctrl;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [4:0] sel_row = '0;
    logic [4:0] sel_col = '0;
    logic [2:0] block;
    logic       load_start = 1'b0;
    logic [1:0] level = '0;
    logic       load_busy;
    logic       load_done;
    logic       hit_req = 1'b0;
    logic [4:0] hit_row = '0;
    logic [4:0] hit_col = '0;
    logic       hit_ack;
    logic [1:0] hit_result;
    logic [8:0] remaining;
    logic       level_clear;
`ifdef BLOCK_MAP_SCORE_EN
    logic [15:0] score;
`endif

    block_map_ctrl dut (
        .clock       (clock),
        .reset       (reset),
        .sel_row     (sel_row),
        .sel_col     (sel_col),
        .block       (block),
        .load_start  (load_start),
        .level       (level),
        .load_busy   (load_busy),
        .load_done   (load_done),
        .hit_req     (hit_req),
        .hit_row     (hit_row),
        .hit_col     (hit_col),
        .hit_ack     (hit_ack),
        .hit_result  (hit_result),
        .remaining   (remaining),
        .level_clear (level_clear)
`ifdef BLOCK_MAP_SCORE_EN
        ,
        .score       (score)
`endif
    );

    always #5 clock = ~clock;

    int         checks = 0;
    int         errors = 0;
    logic [2:0] mdl [30][10];
    int         mdl_rem = 0;
    int         exp_score = 0;
    logic [1:0] exp_q [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic model_clear();
        for (int r = 0; r < 30; r++)
            for (int c = 0; c < 10; c++)
                mdl[r][c] = 3'b000;
        mdl_rem = 0;
    endtask

    // Level 0: rows 2..7 hold {1,(row-2)%4}
    task automatic model_load0();
        logic [2:0] code;
        model_clear();
        for (int r = 0; r < 30; r++) begin
            for (int c = 0; c < 10; c++) begin
                case (r)
                    2, 6:    code = 3'b100;
                    3, 7:    code = 3'b101;
                    4:       code = 3'b110;
                    5:       code = 3'b111;
                    default: code = 3'b000;
                endcase
                mdl[r][c] = code;
                if (code != 3'b000 && code != 3'b111) mdl_rem++;
            end
        end
    endtask

    task automatic model_hit(input int r, input int c, output logic [1:0] res);
        res = 2'b00;
        if (r < 30 && c < 10) begin
            case (mdl[r][c])
                3'b000: res = 2'b00;
                3'b011: begin mdl[r][c] = 3'b001; res = 2'b01; exp_score += 10; end
                3'b111: res = 2'b11;
                default: begin
                    mdl[r][c] = 3'b000;
                    res = 2'b10;
                    if (mdl_rem > 0) mdl_rem--;
                    exp_score += 50;
                end
            endcase
        end
        if (exp_score > 65535) exp_score = 65535;
    endtask

    task automatic scan_map(output int bad);
        bad = 0;
        for (int r = 0; r < 30; r++) begin
            for (int c = 0; c < 10; c++) begin
                sel_row = 5'(r);
                sel_col = 5'(c);
                #1;
                if (block !== mdl[r][c]) bad++;
            end
        end
    endtask

    // Wait for ack on an already-driven request, compare against scoreboard
    task automatic finish_hit(input int r, input int c, input string tag);
        int         lat;
        logic [1:0] e;
        lat = 0;
        while (hit_ack !== 1'b1 && lat < 12) begin
            tick();
            lat++;
        end
        hit_req = 1'b0;
        if (hit_ack !== 1'b1) begin
            check({tag, "_timeout"}, 32'(0), 32'(1));
        end else begin
            if (exp_q.size() == 0) begin
                check({tag, "_sb_empty"}, 32'(0), 32'(1));
            end else begin
                e = exp_q.pop_front();
                check({tag, "_result"}, 32'(hit_result), 32'(e));
            end
            check({tag, "_lat"}, 32'(lat), 32'(3));
            check({tag, "_remaining"}, 32'(remaining), 32'(mdl_rem));
            if (r < 30 && c < 10) check({tag, "_cell"}, 32'(block), 32'(mdl[r][c]));
`ifdef BLOCK_MAP_SCORE_EN
            check({tag, "_score"}, 32'(score), 32'(exp_score));
`endif
        end
        tick();
        check({tag, "_ack_pulse"}, 32'(hit_ack), 32'(0));
    endtask

    task automatic do_hit(input int r, input int c, input string tag);
        logic [1:0] e;
        model_hit(r, c, e);
        exp_q.push_back(e);
        hit_row = 5'(r);
        hit_col = 5'(c);
        sel_row = 5'(r);
        sel_col = 5'(c);
        hit_req = 1'b1;
        finish_hit(r, c, tag);
    endtask

    // Load level 0; optional stray load_start and a pending hit on (2,1)
    task automatic do_load(input int stray_at, input int hit_at,
                           output int busy_n, output int dones, output int acks);
        logic [1:0] e;
        busy_n = 0;
        dones  = 0;
        acks   = 0;
        model_load0();
        level      = 2'd0;
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        level      = 2'd3;
        for (int cyc = 0; cyc < 400 && dones == 0; cyc++) begin
            if (load_busy) busy_n++;
            if (load_done) dones++;
            if (hit_ack) acks++;
            load_start = (cyc == stray_at);
            if (cyc == hit_at) begin
                model_hit(2, 1, e);
                exp_q.push_back(e);
                hit_row = 5'd2;
                hit_col = 5'd1;
                sel_row = 5'd2;
                sel_col = 5'd1;
                hit_req = 1'b1;
            end
            if (dones == 0) tick();
        end
        load_start = 1'b0;
        level      = 2'd0;
    endtask

    initial begin
        int busy_n, dones, acks, bad;

        // 1. reset state
        model_clear();
        tick();
        tick();
        reset = 1'b0;
        tick();
        sel_row = 5'd2;
        sel_col = 5'd0;
        #1;
        check("rst_block", 32'(block), 32'(0));
        check("rst_remaining", 32'(remaining), 32'(0));
        check("rst_level_clear", 32'(level_clear), 32'(0));
        check("rst_busy", 32'(load_busy), 32'(0));
        check("rst_done", 32'(load_done), 32'(0));
        check("rst_ack", 32'(hit_ack), 32'(0));
        check("rst_result", 32'(hit_result), 32'(0));

        // 2. load level 0 with an ignored second load_start
        do_load(50, -1, busy_n, dones, acks);
        check("load_busy_cycles", 32'(busy_n), 32'(300));
        check("load_done_seen", 32'(dones), 32'(1));
        check("load_level_clear", 32'(level_clear), 32'(0));
        tick();
        check("load_done_pulse", 32'(load_done), 32'(0));
        check("load_busy_after", 32'(load_busy), 32'(0));
        sel_row = 5'd2; sel_col = 5'd0; #1;
        check("cell_2_0", 32'(block), 32'(3'b100));
        sel_row = 5'd5; sel_col = 5'd9; #1;
        check("cell_5_9", 32'(block), 32'(3'b111));
        sel_row = 5'd8; sel_col = 5'd0; #1;
        check("cell_8_0", 32'(block), 32'(3'b000));
        sel_row = 5'd2; sel_col = 5'd18; #1;
        check("sel_col_oor", 32'(block), 32'(3'b000));
        sel_row = 5'd31; sel_col = 5'd2; #1;
        check("sel_row_oor", 32'(block), 32'(3'b000));
        check("load_remaining", 32'(remaining), 32'(50));
        scan_map(bad);
        check("load_map_scan", 32'(bad), 32'(0));
        tick();

        // 3. destroy a brick, hit a white one
        do_hit(3, 4, "hit_3_4");
        do_hit(5, 0, "hit_5_0");

        // 4. hit raised during a load stays pending until the load ends
        do_load(-1, 10, busy_n, dones, acks);
        check("pend_busy_cycles", 32'(busy_n), 32'(300));
        check("pend_done_seen", 32'(dones), 32'(1));
        check("pend_no_ack_in_load", 32'(acks), 32'(0));
        finish_hit(2, 1, "pend_hit");
        check("pend_level_clear", 32'(level_clear), 32'(0));

        // 5. out-of-range misses, then clear the level
        do_hit(31, 3, "hit_row_oor");
        do_hit(3, 18, "hit_col_oor");
        sel_row = 5'd3; sel_col = 5'd2; #1;
        check("oor_no_alias_write", 32'(block), 32'(3'b101));
        for (int r = 0; r < 30; r++)
            for (int c = 0; c < 10; c++)
                if (mdl[r][c] != 3'b000 && mdl[r][c] != 3'b111)
                    do_hit(r, c, "clear_all");
        check("level_clear_set", 32'(level_clear), 32'(1));
        do_hit(5, 3, "white_at_zero");
        do_hit(0, 0, "empty_at_zero");
        check("remaining_floor", 32'(remaining), 32'(0));
        check("level_clear_hold", 32'(level_clear), 32'(1));

        // 6. reset in the middle of a load
        level      = 2'd0;
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        for (int i = 0; i < 150; i++) tick();
        check("abort_busy_before", 32'(load_busy), 32'(1));
        reset = 1'b1;
        #1;
        check("abort_busy_async", 32'(load_busy), 32'(0));
        check("abort_remaining", 32'(remaining), 32'(0));
        tick();
        tick();
        reset     = 1'b0;
        exp_score = 0;
        model_clear();
        busy_n = 0;
        dones  = 0;
        for (int i = 0; i < 320; i++) begin
            if (load_done) dones++;
            if (load_busy) busy_n++;
            tick();
        end
        check("abort_no_done", 32'(dones), 32'(0));
        check("abort_no_busy", 32'(busy_n), 32'(0));
        scan_map(bad);
        check("abort_map_clear", 32'(bad), 32'(0));
        check("abort_level_clear", 32'(level_clear), 32'(0));
        tick();

        do_load(-1, -1, busy_n, dones, acks);
        check("reload_done", 32'(dones), 32'(1));
        check("reload_remaining", 32'(remaining), 32'(50));
        tick();
        do_hit(2, 0, "score_hit_a");
        do_hit(3, 0, "score_hit_b");
`ifdef BLOCK_MAP_SCORE_EN
        check("score_two_destroys", 32'(score), 32'(100));
`endif
        check("sb_drained", 32'(exp_q.size()), 32'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
